// File: rtl/vcve2_dmem_arbiter_if.sv
// OBI-style request/response bundle with N lanes; the arbiter uses an N=NumReq
// instance toward the requesters and an N=1 instance toward data memory.
interface vcve2_dmem_arbiter_if #(
    parameter int unsigned N = 1
);
    logic [N-1:0]       req;
    logic [N-1:0]       gnt;
    logic [N-1:0]       we;
    logic [N-1:0][3:0]  be;
    logic [N-1:0][31:0] addr;
    logic [N-1:0][31:0] wdata;
    logic [N-1:0]       rvalid;
    logic [N-1:0][31:0] rdata;
    logic [N-1:0]       err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/vcve2_dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NumReq requesters, with
// optional per-requester lock and an in-order FIFO that routes responses back.
module vcve2_dmem_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    vcve2_dmem_arbiter_if.slave         req_bus,
    vcve2_dmem_arbiter_if.master        mem_bus,
    input  logic [NumReq-1:0]           lock_i,
    output logic                        busy_o,
    output logic [CntW-1:0]             outstanding_o,
    output logic                        protocol_err_o
);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [IdxW-1:0]                      rr_ptr_q;
    logic                                 lock_q;
    logic [IdxW-1:0]                      lock_owner_q;
    logic [MaxOutstanding-1:0][IdxW-1:0]  fifo_q;
    logic [PtrW-1:0]                      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]                      count_q;
    logic                                 protocol_err_q;

    logic [NumReq-1:0] elig;
    logic              win_valid;
    logic [IdxW-1:0]   win_idx;
    logic              can_issue, hs, pop;
    logic [IdxW-1:0]   head;
    int unsigned       j;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        elig = req_bus.req;
        if (lock_q) begin
            elig               = '0;
            elig[lock_owner_q] = req_bus.req[lock_owner_q];
        end
    end

    // First eligible index scanning upward from rr_ptr_q, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            j = (32'(rr_ptr_q) + i) % NumReq;
            if (!win_valid && elig[j]) begin
                win_valid = 1'b1;
                win_idx   = IdxW'(j);
            end
        end
    end

    assign can_issue = (count_q < CntW'(MaxOutstanding));
    assign hs        = mem_bus.req[0] & mem_bus.gnt[0];
    assign pop       = mem_bus.rvalid[0] & (count_q != '0);
    assign head      = fifo_q[rd_ptr_q];

    always_comb begin
        mem_bus.req   = '0;
        mem_bus.we    = '0;
        mem_bus.be    = '0;
        mem_bus.addr  = '0;
        mem_bus.wdata = '0;
        if (rst_ni && win_valid) begin
            mem_bus.req[0]   = can_issue;
            mem_bus.we[0]    = req_bus.we[win_idx];
            mem_bus.be[0]    = req_bus.be[win_idx];
            mem_bus.addr[0]  = req_bus.addr[win_idx];
            mem_bus.wdata[0] = req_bus.wdata[win_idx];
        end
    end

    always_comb begin
        req_bus.gnt    = '0;
        req_bus.rvalid = '0;
        req_bus.err    = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            req_bus.rdata[i] = mem_bus.rdata[0];
        end
        if (hs) req_bus.gnt[win_idx] = 1'b1;
        if (pop) begin
            req_bus.rvalid[head] = 1'b1;
            req_bus.err[head]    = mem_bus.err[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q       <= '0;
            lock_q         <= 1'b0;
            lock_owner_q   <= '0;
            fifo_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            if (hs) begin
                fifo_q[wr_ptr_q] <= win_idx;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
                lock_q           <= lock_i[win_idx];
                if (lock_i[win_idx]) begin
                    lock_owner_q <= win_idx;
                end else begin
                    rr_ptr_q <= (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + 1'b1;
                end
            end else if (lock_q && !req_bus.req[lock_owner_q] && !lock_i[lock_owner_q]) begin
                lock_q <= 1'b0;
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (hs && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!hs && pop) begin
                count_q <= count_q - 1'b1;
            end
            // A response with nothing outstanding is dropped but remembered.
            if (mem_bus.rvalid[0] && count_q == '0) protocol_err_q <= 1'b1;
        end
    end

    assign busy_o         = (count_q != '0) | lock_q;
    assign outstanding_o  = count_q;
    assign protocol_err_o = protocol_err_q;
endmodule
